// File: rtl/result_bank.sv
// result_bank: output-side buffer of the 3x3 matmul accelerator.
// Collects three result rows (one per strobe, three lanes wide) and then
// streams the nine elements row-major over a valid/ready handshake.

// Per-lane column storage: holds one column (three rows) of the result.
module result_bank_lane #(
  parameter int RW   = 10,
  parameter int ROWS = 3
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      wr,
  input  logic [1:0]                row,
  input  logic [RW-1:0]             din,
  output logic [ROWS-1:0][RW-1:0]   col
);

  // Write the addressed row of this column on an accepted strobe.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      col <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (wr && (row == i[1:0])) col[i] <= din;
      end
    end
  end

endmodule

module result_bank #(
  parameter int RW = 10
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          row_valid,
  input  logic [RW-1:0] res_in1,
  input  logic [RW-1:0] res_in2,
  input  logic [RW-1:0] res_in3,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [RW-1:0] data_out,
  output logic          out_last,
  output logic [1:0]    row_cnt,
  output logic          busy,
  output logic          done,
  output logic          drop
);

  localparam int NUM_LANES = 3;
  localparam int ROWS      = 3;
  localparam int ELEMS     = NUM_LANES * ROWS;

  typedef enum logic {COLLECT, STREAM} state_t;

  state_t state;
  logic [3:0] idx;
  logic [3:0] nxt;

  logic [NUM_LANES-1:0][RW-1:0]           lane_in;
  logic [NUM_LANES-1:0][ROWS-1:0][RW-1:0] lane_q;
  logic [ELEMS-1:0][RW-1:0]               elem;

  logic xfer, last_xfer, accept;
  logic [1:0] wr_row;

  assign lane_in = {res_in3, res_in2, res_in1};

  // Handshake and capture qualification. The final transfer edge doubles as
  // a capture edge for row 0 of the next matrix.
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (idx == 4'd8);
  assign accept    = row_valid && ((state == COLLECT) || last_xfer);
  assign wr_row    = (state == COLLECT) ? row_cnt : 2'd0;
  assign nxt       = idx + 4'd1;

  genvar c, r;
  generate
    for (c = 0; c < NUM_LANES; c++) begin : g_lane
      result_bank_lane #(.RW(RW), .ROWS(ROWS)) u_lane (
        .clk   (clk),
        .clear (clear),
        .wr    (accept),
        .row   (wr_row),
        .din   (lane_in[c]),
        .col   (lane_q[c])
      );
      // Row-major element view: k = row*3 + col.
      for (r = 0; r < ROWS; r++) begin : g_row
        assign elem[r*NUM_LANES + c] = lane_q[c][r];
      end
    end
  endgenerate

  // Control FSM with registered outputs; data_out is preloaded with the
  // element that becomes current on each edge so it never comes from a mux.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= COLLECT;
      idx       <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (row_valid && (state == STREAM) && !last_xfer) drop <= 1'b1;
      case (state)
        COLLECT: begin
          if (row_valid) begin
            if (row_cnt == 2'd2) begin
              state     <= STREAM;
              row_cnt   <= 2'd3;
              idx       <= '0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              data_out  <= elem[0];
              out_last  <= 1'b0;
            end else begin
              row_cnt <= row_cnt + 2'd1;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (idx == 4'd8) begin
              state     <= COLLECT;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              idx       <= '0;
              out_last  <= 1'b0;
              data_out  <= '0;
              done      <= 1'b1;
              row_cnt   <= row_valid ? 2'd1 : 2'd0;
            end else begin
              idx      <= nxt;
              data_out <= elem[nxt];
              out_last <= (idx == 4'd7);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bank.sv
// Bench for result_bank: table of matrices streamed with a scoreboard,
// plus hand sequences for drop, async clear mid-stream and overlap.
module tb_result_bank;

  localparam int RW = 10;
  typedef logic [8:0][RW-1:0] mat_t;
  typedef struct { mat_t m; int gap; int stall_at; int stall_len; } vec_t;
  typedef struct { int val; bit last; } exp_t;

  logic clk = 0, clear = 1, row_valid = 0, out_ready = 1;
  logic [RW-1:0] res_in1 = '0, res_in2 = '0, res_in3 = '0;
  logic out_valid, out_last, busy, done, drop;
  logic [RW-1:0] data_out;
  logic [1:0] row_cnt;

  int checks = 0, errors = 0;
  exp_t sb[$];
  vec_t tbl[4];

  result_bank #(.RW(RW)) dut (
    .clk(clk), .clear(clear), .row_valid(row_valid),
    .res_in1(res_in1), .res_in2(res_in2), .res_in3(res_in3),
    .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out),
    .out_last(out_last), .row_cnt(row_cnt), .busy(busy), .done(done),
    .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mat_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    mat_t m;
    m[0] = a0[RW-1:0]; m[1] = a1[RW-1:0]; m[2] = a2[RW-1:0];
    m[3] = a3[RW-1:0]; m[4] = a4[RW-1:0]; m[5] = a5[RW-1:0];
    m[6] = a6[RW-1:0]; m[7] = a7[RW-1:0]; m[8] = a8[RW-1:0];
    return m;
  endfunction

  // Scoreboard monitor: every valid cycle must show the queue head.
  always @(negedge clk) begin
    if (!clear) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("data_out", int'(data_out), sb[0].val);
          chk("out_last", int'(out_last), int'(sb[0].last));
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("last_idle", int'(out_last), 0);
      end
    end
  end

  // Load rows first_row..2 of m; called and returns at posedge+1.
  task automatic load(input mat_t m, input int gap, input int first_row);
    for (int r = first_row; r < 3; r++) begin
      row_valid = 1;
      res_in1 = m[3*r]; res_in2 = m[3*r+1]; res_in3 = m[3*r+2];
      for (int c = 0; c < 3; c++) sb.push_back('{int'(m[3*r+c]), (3*r+c) == 8});
      @(posedge clk); #1;
      row_valid = 0;
      chk("row_cnt_step", int'(row_cnt), r + 1);
      chk("fill_valid", int'(out_valid), int'(r == 2));
      chk("fill_busy", int'(busy), int'(r == 2));
      if (r < 2) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          chk("gap_row_cnt", int'(row_cnt), r + 1);
          chk("gap_valid", int'(out_valid), 0);
        end
      end
    end
  endtask

  // Drive out_ready until nine transfers; optional stall and row injection.
  task automatic stream(input int stall_at, input int stall_len,
                        input int inj_at, input bit overlap);
    int k = 0, stalled = 0, cyc = 0;
    bit x, inj;
    while (k < 9 && cyc < 200) begin
      out_ready = 1;
      inj = 0;
      if (k == stall_at && stalled < stall_len) begin
        out_ready = 0;
        stalled++;
        chk("hold_valid", int'(out_valid), 1);
        if (sb.size() > 0) chk("hold_data", int'(data_out), sb[0].val);
      end
      if (k == inj_at && out_ready) begin
        inj = 1;
        row_valid = 1;
        if (overlap) begin
          res_in1 = 10; res_in2 = 11; res_in3 = 12;
          for (int c = 0; c < 3; c++) sb.push_back('{10 + c, 1'b0});
        end else begin
          res_in1 = 9; res_in2 = 9; res_in3 = 9;
        end
      end
      @(negedge clk);
      x = out_valid && out_ready;
      @(posedge clk); #1;
      row_valid = 0;
      if (inj && !overlap) begin
        chk("drop_set", int'(drop), 1);
        chk("drop_row_cnt", int'(row_cnt), 3);
      end
      if (x) k++;
      cyc++;
    end
    chk("stream_count", k, 9);
    chk("done_pulse", int'(done), 1);
    chk("end_busy", int'(busy), 0);
    chk("end_valid", int'(out_valid), 0);
    chk("end_row_cnt", int'(row_cnt), overlap ? 1 : 0);
    @(posedge clk); #1;
    chk("done_clear", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{mk(1,2,3,4,5,6,7,8,675), 0, -1, 0};
    tbl[1] = '{mk(1,2,3,4,5,6,7,8,675), 0, 2, 4};
    tbl[2] = '{mk(100,200,300,400,500,600,11,22,33), 5, -1, 0};
    tbl[3] = '{mk(1023,0,512,7,1022,64,255,256,1), 2, 8, 2};

    // Reset state, and strobes ignored while clear is high.
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_row_cnt", int'(row_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_drop", int'(drop), 0);
    row_valid = 1; res_in1 = 5; res_in2 = 5; res_in3 = 5;
    @(posedge clk); #1;
    row_valid = 0; clear = 0;
    chk("clear_ignores_row", int'(row_cnt), 0);

    for (int i = 0; i < 4; i++) begin
      load(tbl[i].m, tbl[i].gap, 0);
      stream(tbl[i].stall_at, tbl[i].stall_len, -1, 0);
      chk("sb_empty", sb.size(), 0);
    end

    // Drop: strobe at idx 4 is ignored and drop sticks.
    load(mk(31,32,33,34,35,36,37,38,39), 0, 0);
    stream(-1, 0, 4, 0);
    chk("drop_sticky", int'(drop), 1);
    chk("drop_sb_empty", sb.size(), 0);

    // Async clear at idx 5, between edges.
    load(mk(41,42,43,44,45,46,47,48,49), 0, 0);
    repeat (5) @(posedge clk);
    #3 clear = 1;
    #1;
    chk("aclr_valid", int'(out_valid), 0);
    chk("aclr_busy", int'(busy), 0);
    chk("aclr_drop", int'(drop), 0);
    chk("aclr_data", int'(data_out), 0);
    chk("aclr_row_cnt", int'(row_cnt), 0);
    sb.delete();
    @(posedge clk); #1;
    clear = 0;
    load(mk(51,52,53,54,55,56,57,58,59), 0, 0);
    stream(-1, 0, -1, 0);
    chk("aclr_sb_empty", sb.size(), 0);

    // Overlap: row 0 of the next matrix rides the final transfer edge.
    load(mk(61,62,63,64,65,66,67,68,69), 0, 0);
    stream(-1, 0, 8, 1);
    chk("ovl_drop", int'(drop), 0);
    load(mk(0,0,0,13,14,15,16,17,18), 0, 1);
    stream(-1, 0, -1, 0);
    chk("ovl_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
